packet_tx_serializer: RTL and testbench

// - Downstream stage of reward: captures the response packet fields (r*) when reward_done pulses.
// - Serializes those fields into an 8-bit byte stream toward the radio TX buffer.
// - Uses a valid/ready handshake on the byte stream.
// - Sole path by which reward-generated packets leave the node; one packet in flight at a time.

---
 rtl/packet_tx_serializer.sv | 144 ++++++++++++++
 tb/tb_packet_tx_serializer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_tx_serializer.sv
// Captures a reward response packet and streams it out as big-endian bytes over valid/ready.
// Define TX_CHECKSUM_EN to append an XOR checksum byte to every frame.
module packet_tx_serializer #(
  parameter int WORD_WIDTH = 16,
  parameter int MEM_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reward_done,
  input  logic [2:0]            rPacketType,
  input  logic [WORD_WIDTH-1:0] rSourceID,
  input  logic [WORD_WIDTH-1:0] rDestinationID,
  input  logic [WORD_WIDTH-1:0] rSourceHops,
  input  logic [WORD_WIDTH-1:0] rQValue,
  input  logic [WORD_WIDTH-1:0] rEnergyLeft,
  input  logic [WORD_WIDTH-1:0] rChosenCH,
  input  logic [WORD_WIDTH-1:0] rHopsFromCH,
  input  logic                  tx_ready,
  output logic [MEM_WIDTH-1:0]  tx_data,
  output logic                  tx_valid,
  output logic                  tx_last,
  output logic                  busy,
  output logic                  tx_done,
  output logic                  drop_err
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam int NUM_WORDS = 7;

  state_t                               state_q, state_d;
  logic [3:0]                           idx_q, idx_d;
  logic [2:0]                           type_q, type_d;
  logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] words_q, words_d;
  logic                                 drop_err_q, drop_err_d;
`ifdef TX_CHECKSUM_EN
  logic [MEM_WIDTH-1:0]                 csum_q, csum_d;
`endif

  logic                  is_short;
  logic [3:0]            last_idx;
  logic [3:0]            full_idx;
  logic [2:0]            word_idx;
  logic [WORD_WIDTH-1:0] sel_word;
  logic [MEM_WIDTH-1:0]  cur_byte;

  assign is_short = (type_q == 3'd1);

`ifdef TX_CHECKSUM_EN
  assign last_idx = is_short ? 4'd9 : 4'd15;
`else
  assign last_idx = is_short ? 4'd8 : 4'd14;
`endif

  // Short frames skip DestinationID, so from byte 3 on they map two slots further into the full layout.
  always_comb begin
    full_idx = (is_short && (idx_q >= 4'd3)) ? idx_q + 4'd2 : idx_q;
    word_idx = 3'((full_idx - 4'd1) >> 1);
    sel_word = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (word_idx == 3'(i)) sel_word = words_q[i];
    end
    if (full_idx == 4'd0)
      cur_byte = {{(MEM_WIDTH-3){1'b0}}, type_q};
    else if (full_idx[0])
      cur_byte = sel_word[WORD_WIDTH-1 -: MEM_WIDTH];
    else
      cur_byte = sel_word[MEM_WIDTH-1:0];
`ifdef TX_CHECKSUM_EN
    if (idx_q == last_idx) cur_byte = csum_q;
`endif
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    type_d     = type_q;
    words_d    = words_q;
    drop_err_d = drop_err_q;
`ifdef TX_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (reward_done) begin
          if (rPacketType != 3'd0) begin
            type_d  = rPacketType;
            words_d = {rHopsFromCH, rChosenCH, rEnergyLeft, rQValue,
                       rSourceHops, rDestinationID, rSourceID};
            idx_d   = 4'd0;
`ifdef TX_CHECKSUM_EN
            csum_d  = '0;
`endif
            state_d = SEND;
          end else begin
            drop_err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (reward_done) drop_err_d = 1'b1;
        if (tx_ready) begin
          idx_d = idx_q + 4'd1;
`ifdef TX_CHECKSUM_EN
          csum_d = csum_q ^ cur_byte;
`endif
          if (idx_q == last_idx) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      type_q     <= '0;
      words_q    <= '0;
      drop_err_q <= 1'b0;
`ifdef TX_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      type_q     <= type_d;
      words_q    <= words_d;
      drop_err_q <= drop_err_d;
`ifdef TX_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign tx_valid = (state_q == SEND);
  assign tx_data  = tx_valid ? cur_byte : '0;
  assign tx_last  = tx_valid && (idx_q == last_idx);
  assign busy     = (state_q == SEND);
  assign tx_done  = (state_q == DONE);
  assign drop_err = drop_err_q;

endmodule

// File: tb/tb_packet_tx_serializer.sv
// Scoreboard bench for packet_tx_serializer; expected frames are built from the field values
// and pushed to a queue, then popped as the DUT hands over each accepted byte.
module tb_packet_tx_serializer;

  typedef logic [6:0][15:0] fields_t;

  logic        clk = 1'b0;
  logic        rst, reward_done, tx_ready;
  logic [2:0]  rPacketType;
  logic [15:0] rSourceID, rDestinationID, rSourceHops, rQValue, rEnergyLeft, rChosenCH, rHopsFromCH;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_last, busy, tx_done, drop_err;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];

  packet_tx_serializer #(.WORD_WIDTH(16), .MEM_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .reward_done(reward_done), .rPacketType(rPacketType),
    .rSourceID(rSourceID), .rDestinationID(rDestinationID), .rSourceHops(rSourceHops),
    .rQValue(rQValue), .rEnergyLeft(rEnergyLeft), .rChosenCH(rChosenCH),
    .rHopsFromCH(rHopsFromCH), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_last(tx_last), .busy(busy), .tx_done(tx_done),
    .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  // Word order: 0 SourceID, 1 DestinationID, 2 SourceHops, 3 QValue, 4 EnergyLeft, 5 ChosenCH, 6 HopsFromCH.
  function automatic void push_frame(input logic [2:0] t, input fields_t f);
    logic [7:0] cs;
    cs = {5'b0, t};
    exp_q.push_back(cs);
    for (int w = 0; w < 7; w++) begin
      if (t == 3'd1 && (w == 1 || w == 5 || w == 6)) continue;
      exp_q.push_back(f[w][15:8]);
      exp_q.push_back(f[w][7:0]);
      cs = cs ^ f[w][15:8] ^ f[w][7:0];
    end
`ifdef TX_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endfunction

  function automatic fields_t rand_fields();
    fields_t f;
    for (int i = 0; i < 7; i++) f[i] = 16'($urandom);
    return f;
  endfunction

  // Called and returns on a falling edge; the reward_done pulse spans exactly one rising edge.
  task automatic pulse_reward(input logic [2:0] t, input fields_t f);
    rPacketType = t;
    rSourceID = f[0]; rDestinationID = f[1]; rSourceHops = f[2]; rQValue = f[3];
    rEnergyLeft = f[4]; rChosenCH = f[5]; rHopsFromCH = f[6];
    reward_done = 1'b1;
    @(negedge clk);
    reward_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; reward_done = 1'b0; tx_ready = 1'b0; rPacketType = 3'd0;
    rSourceID = '0; rDestinationID = '0; rSourceHops = '0; rQValue = '0;
    rEnergyLeft = '0; rChosenCH = '0; rHopsFromCH = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx_valid, tx_last, busy, tx_done, drop_err, tx_data} !== 13'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %b want 0", {tx_valid, tx_last, busy, tx_done, drop_err, tx_data});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx_valid, busy, tx_done} !== 3'b0) begin
      errors++; $display("[TB] FAIL reset_idle got %b want 000", {tx_valid, busy, tx_done});
    end
  endtask

  task automatic test_full_frame();
    fields_t    f;
    logic [7:0] exp;
    int         cycles, n;
    f = {16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h0003, 16'h000C};
    tx_ready = 1'b1;
    push_frame(3'd2, f);
    n = exp_q.size();
    pulse_reward(3'd2, f);
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 50) begin
      checks++;
      if ({tx_valid, busy} !== 2'b11) begin
        errors++; $display("[TB] FAIL full_valid_busy got %b want 11", {tx_valid, busy});
      end
      if (tx_valid) begin
        exp = exp_q.pop_front();
        checks++;
        if (tx_data !== exp) begin
          errors++; $display("[TB] FAIL full_data byte %0d got %h want %h", n - exp_q.size(), tx_data, exp);
        end
        checks++;
        if (tx_last !== (exp_q.size() == 0)) begin
          errors++; $display("[TB] FAIL full_last byte %0d got %b", n - exp_q.size(), tx_last);
        end
      end
      @(negedge clk); cycles++;
    end
    checks++;
    if (exp_q.size() != 0 || cycles != n) begin
      errors++; $display("[TB] FAIL full_length cycles %0d want %0d left %0d", cycles, n, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if ({tx_done, tx_valid, busy} !== 3'b100) begin
      errors++; $display("[TB] FAIL full_done got %b want 100", {tx_done, tx_valid, busy});
    end
    @(negedge clk);
    checks++;
    if ({tx_done, busy} !== 2'b00) begin
      errors++; $display("[TB] FAIL full_idle got %b want 00", {tx_done, busy});
    end
  endtask

  task automatic test_short_frame();
    fields_t    f;
    logic [7:0] exp;
    int         cycles, n;
    f = {16'hAAAA, 16'h5555, 16'h8000, 16'h0000, 16'h0001, 16'hBEEF, 16'h000C};
    tx_ready = 1'b1;
    push_frame(3'd1, f);
    n = exp_q.size();
    pulse_reward(3'd1, f);
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 50) begin
      if (tx_valid) begin
        exp = exp_q.pop_front();
        checks++;
        if (tx_data !== exp) begin
          errors++; $display("[TB] FAIL short_data byte %0d got %h want %h", n - exp_q.size(), tx_data, exp);
        end
        checks++;
        if (tx_last !== (exp_q.size() == 0)) begin
          errors++; $display("[TB] FAIL short_last byte %0d got %b", n - exp_q.size(), tx_last);
        end
      end
      @(negedge clk); cycles++;
    end
    checks++;
    if (exp_q.size() != 0 || cycles != n) begin
      errors++; $display("[TB] FAIL short_length cycles %0d want %0d", cycles, n);
      exp_q.delete();
    end
    checks++;
    if (tx_done !== 1'b1) begin
      errors++; $display("[TB] FAIL short_done got %b want 1", tx_done);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    fields_t    f;
    logic [7:0] exp, prev_data;
    logic       prev_stall;
    int         cycles;
    for (int rep = 0; rep < 3; rep++) begin
      f = rand_fields();
      push_frame((rep == 1) ? 3'd1 : 3'(5 + rep), f);
      pulse_reward((rep == 1) ? 3'd1 : 3'(5 + rep), f);
      cycles = 0; prev_stall = 1'b0; prev_data = '0;
      while (exp_q.size() > 0 && cycles < 500) begin
        tx_ready = 1'($urandom_range(0, 1));
        if (prev_stall) begin
          checks++;
          if ({tx_valid, tx_data} !== {1'b1, prev_data}) begin
            errors++; $display("[TB] FAIL bp_stable got %b/%h want 1/%h", tx_valid, tx_data, prev_data);
          end
        end
        if (tx_valid && tx_ready) begin
          exp = exp_q.pop_front();
          checks++;
          if ({tx_data, tx_last} !== {exp, exp_q.size() == 0}) begin
            errors++; $display("[TB] FAIL bp_data got %h/%b want %h/%b", tx_data, tx_last, exp, exp_q.size() == 0);
          end
          prev_stall = 1'b0;
        end else begin
          prev_stall = tx_valid;
        end
        prev_data = tx_data;
        @(negedge clk); cycles++;
      end
      tx_ready = 1'b1;
      checks++;
      if (exp_q.size() != 0 || tx_done !== 1'b1) begin
        errors++; $display("[TB] FAIL bp_done left %0d tx_done %b", exp_q.size(), tx_done);
        exp_q.delete();
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    fields_t    fa, fb;
    logic [7:0] exp;
    int         cycles, len_b;
    logic       b_sent;
    fa = rand_fields(); fb = rand_fields();
    tx_ready = 1'b1;
    push_frame(3'd1, fa);
    len_b = exp_q.size();
    push_frame(3'd7, fb);
    len_b = exp_q.size() - len_b;
    pulse_reward(3'd1, fa);
    cycles = 0; b_sent = 1'b0;
    while (exp_q.size() > 0 && cycles < 100) begin
      if (tx_valid) begin
        exp = exp_q.pop_front();
        checks++;
        if ({tx_data, tx_last} !== {exp, (exp_q.size() == 0) || (exp_q.size() == len_b)}) begin
          errors++; $display("[TB] FAIL b2b_data got %h/%b want %h", tx_data, tx_last, exp);
        end
        if (!b_sent && exp_q.size() == len_b) begin
          @(negedge clk); cycles++;
          checks++;
          if ({tx_done, busy} !== 2'b10) begin
            errors++; $display("[TB] FAIL b2b_gap got %b want 10", {tx_done, busy});
          end
          pulse_reward(3'd7, fb);
          b_sent = 1'b1;
          cycles++;
          continue;
        end
      end
      @(negedge clk); cycles++;
    end
    checks++;
    if (exp_q.size() != 0 || tx_done !== 1'b1 || drop_err !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_end left %0d tx_done %b drop_err %b", exp_q.size(), tx_done, drop_err);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_drop_type0();
    rPacketType = 3'd0;
    reward_done = 1'b1;
    @(negedge clk);
    reward_done = 1'b0;
    checks++;
    if ({busy, tx_valid, drop_err} !== 3'b001) begin
      errors++; $display("[TB] FAIL drop0_flags got %b want 001", {busy, tx_valid, drop_err});
    end
    @(negedge clk);
    checks++;
    if ({busy, drop_err} !== 2'b01) begin
      errors++; $display("[TB] FAIL drop0_sticky got %b want 01", {busy, drop_err});
    end
  endtask

  task automatic test_drop_busy();
    fields_t    f;
    logic [7:0] exp;
    int         cycles;
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    checks++;
    if (drop_err !== 1'b0) begin
      errors++; $display("[TB] FAIL dropbusy_clear got %b want 0", drop_err);
    end
    f = rand_fields();
    tx_ready = 1'b1;
    push_frame(3'd4, f);
    pulse_reward(3'd4, f);
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 50) begin
      if (cycles == 4) begin
        rPacketType = 3'd3; rSourceID = ~rSourceID; rDestinationID = ~rDestinationID;
        rSourceHops = ~rSourceHops; rQValue = ~rQValue; rEnergyLeft = ~rEnergyLeft;
        rChosenCH = ~rChosenCH; rHopsFromCH = ~rHopsFromCH;
        reward_done = 1'b1;
      end else begin
        reward_done = 1'b0;
      end
      if (tx_valid) begin
        exp = exp_q.pop_front();
        checks++;
        if ({tx_data, tx_last} !== {exp, exp_q.size() == 0}) begin
          errors++; $display("[TB] FAIL dropbusy_data got %h/%b want %h", tx_data, tx_last, exp);
        end
      end
      @(negedge clk); cycles++;
    end
    reward_done = 1'b0;
    checks++;
    if (exp_q.size() != 0 || {tx_done, drop_err} !== 2'b11) begin
      errors++; $display("[TB] FAIL dropbusy_end left %0d done/drop %b want 11", exp_q.size(), {tx_done, drop_err});
      exp_q.delete();
    end
    @(negedge clk);
    checks++;
    if ({busy, tx_valid} !== 2'b00) begin
      errors++; $display("[TB] FAIL dropbusy_nostart got %b want 00", {busy, tx_valid});
    end
  endtask

  task automatic test_reset_mid_frame();
    fields_t    f;
    logic [7:0] exp;
    int         cycles;
    f = rand_fields();
    tx_ready = 1'b1;
    push_frame(3'd6, f);
    pulse_reward(3'd6, f);
    for (int i = 0; i < 5; i++) begin
      exp = exp_q.pop_front();
      checks++;
      if (tx_data !== exp) begin
        errors++; $display("[TB] FAIL midrst_pre byte %0d got %h want %h", i, tx_data, exp);
      end
      @(negedge clk);
    end
    exp_q.delete();
    rst = 1'b1;
    #1;
    checks++;
    if ({tx_valid, tx_last, busy, tx_done, drop_err, tx_data} !== 13'b0) begin
      errors++; $display("[TB] FAIL midrst_outputs got %b want 0", {tx_valid, tx_last, busy, tx_done, drop_err, tx_data});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx_done, tx_valid, busy} !== 3'b000) begin
      errors++; $display("[TB] FAIL midrst_nodone got %b want 000", {tx_done, tx_valid, busy});
    end
    f = rand_fields();
    push_frame(3'd1, f);
    pulse_reward(3'd1, f);
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 50) begin
      if (tx_valid) begin
        exp = exp_q.pop_front();
        checks++;
        if ({tx_data, tx_last} !== {exp, exp_q.size() == 0}) begin
          errors++; $display("[TB] FAIL midrst_post got %h/%b want %h", tx_data, tx_last, exp);
        end
      end
      @(negedge clk); cycles++;
    end
    checks++;
    if (exp_q.size() != 0 || tx_done !== 1'b1) begin
      errors++; $display("[TB] FAIL midrst_end left %0d tx_done %b", exp_q.size(), tx_done);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_backpressure();
    test_back_to_back();
    test_drop_type0();
    test_drop_busy();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
